// File: rtl/apb_mem_arbiter_if.sv
// Requester handshakes plus the APB master bus of apb_mem_arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's.
interface apb_mem_arbiter_if #(
  parameter int ADDR = 10,
  parameter int DATA = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*DATA-1:0] req_wdata;
  logic [NREQ-1:0]      req_grant;
  logic [NREQ-1:0]      req_done;
  logic                 req_err;
  logic [DATA-1:0]      req_rdata;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDR-1:0]      paddr;
  logic [DATA-1:0]      pwdata;
  logic                 pready;
  logic [DATA-1:0]      prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, pready, prdata,
    output req_grant, req_done, req_err, req_rdata,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, pready, prdata,
    input  req_grant, req_done, req_err, req_rdata,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_mem_arbiter.sv
// Round-robin arbiter sharing one APB memory slave between NREQ requesters.
// One transfer in flight at a time: IDLE -> SETUP -> ACCESS -> DONE.
module apb_mem_arbiter #(
  parameter int ADDR    = 10,
  parameter int DATA    = 32,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input logic               pclk,
  input logic               preset,
  apb_mem_arbiter_if.master bus
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  typedef logic [IDXW:0] wide_idx_t;
  localparam wide_idx_t NREQ_W = wide_idx_t'(NREQ);

  state_t          state_reg, state_next;
  logic [IDXW-1:0] owner_reg, last_reg;
  logic            pwrite_reg;
  logic [ADDR-1:0] paddr_reg;
  logic [DATA-1:0] pwdata_reg;
  logic [CW-1:0]   wait_cnt_reg;
  logic            abort_reg;
  logic [NREQ-1:0] done_reg;
  logic            err_reg;
  logic [DATA-1:0] rdata_reg;
  logic            timeout_hit;

  logic [ADDR-1:0] addr_arr  [NREQ];
  logic [DATA-1:0] wdata_arr [NREQ];
  logic [NREQ-1:0] owner_oh;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi]  = bus.req_addr[gi*ADDR +: ADDR];
      assign wdata_arr[gi] = bus.req_wdata[gi*DATA +: DATA];
      assign owner_oh[gi]  = (owner_reg == IDXW'(gi));
    end
  endgenerate

  // Rotate the request vector so bit 0 is requester last+1, then take the
  // lowest set bit and rotate the index back.
  logic [2*NREQ-1:0] dbl_shift;
  logic [NREQ-1:0]   rot_valid;
  logic [IDXW-1:0]   rot_sel;
  logic [IDXW-1:0]   winner;
  wide_idx_t         start_w, win_sum;
  logic              any_valid;

  assign start_w   = {1'b0, last_reg} + wide_idx_t'(1);
  assign dbl_shift = {bus.req_valid, bus.req_valid} >> start_w;
  assign rot_valid = dbl_shift[NREQ-1:0];
  assign any_valid = |bus.req_valid;

  always_comb begin
    rot_sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) rot_sel = IDXW'(k);
    end
  end

  assign win_sum = start_w + {1'b0, rot_sel};
  assign winner  = (win_sum >= NREQ_W) ? IDXW'(win_sum - NREQ_W) : IDXW'(win_sum);

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == TO_LAST);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (bus.pready || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      owner_reg    <= '0;
      last_reg     <= IDXW'(NREQ - 1);
      pwrite_reg   <= 1'b0;
      paddr_reg    <= '0;
      pwdata_reg   <= '0;
      wait_cnt_reg <= '0;
      abort_reg    <= 1'b0;
      done_reg     <= '0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      done_reg <= '0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            owner_reg    <= winner;
            last_reg     <= winner;
            pwrite_reg   <= bus.req_write[winner];
            paddr_reg    <= addr_arr[winner];
            pwdata_reg   <= wdata_arr[winner];
            wait_cnt_reg <= '0;
            abort_reg    <= 1'b0;
          end
        end
        ACCESS: begin
          if (!bus.pready) begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
            if (timeout_hit) abort_reg <= 1'b1;
          end
        end
        DONE: begin
          done_reg <= owner_oh;
          err_reg  <= abort_reg;
          // prdata is registered in the slave, so it is valid during DONE
          if (!pwrite_reg && !abort_reg) rdata_reg <= bus.prdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.psel      = (state_reg == SETUP) || (state_reg == ACCESS);
  assign bus.penable   = (state_reg == ACCESS);
  assign bus.pwrite    = pwrite_reg;
  assign bus.paddr     = paddr_reg;
  assign bus.pwdata    = pwdata_reg;
  assign bus.req_grant = (state_reg == SETUP) ? owner_oh : '0;
  assign bus.req_done  = done_reg;
  assign bus.req_err   = err_reg;
  assign bus.req_rdata = rdata_reg;
endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Bench for apb_mem_arbiter: requester drivers push expectations into per-requester
// queues; a monitor checks grants, APB behaviour, completion timing and data.
module tb_apb_mem_arbiter;
  localparam int ADDR    = 10;
  localparam int DATA    = 32;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  typedef struct {
    bit          is_read;
    bit          err;
    int          stall;
    int          addr;
    logic [31:0] rdata;
  } sb_item_t;

  logic pclk;
  logic preset;
  apb_mem_arbiter_if #(.ADDR(ADDR), .DATA(DATA), .NREQ(NREQ)) bus ();

  apb_mem_arbiter #(.ADDR(ADDR), .DATA(DATA), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  int checks;
  int failures;

  bit              v_valid [NREQ];
  bit              v_write [NREQ];
  logic [ADDR-1:0] v_addr  [NREQ];
  logic [DATA-1:0] v_wdata [NREQ];
  int              cur_stall [NREQ];

  sb_item_t          exp_q [NREQ][$];
  logic [31:0]       ref_mem [int];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_drv
      assign bus.req_valid[gi]                = v_valid[gi];
      assign bus.req_write[gi]                = v_write[gi];
      assign bus.req_addr[gi*ADDR +: ADDR]    = v_addr[gi];
      assign bus.req_wdata[gi*DATA +: DATA]   = v_wdata[gi];
    end
  endgenerate

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return 0;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // APB memory slave: stalls each transfer by the stall count its requester asked for
  logic [31:0] mem [1024];
  int          stall_left;
  logic [31:0] prdata_r;

  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      stall_left <= 0;
      prdata_r   <= '0;
      for (int k = 0; k < 1024; k++) mem[k] <= '0;
    end else if (bus.psel && !bus.penable) begin
      stall_left <= cur_stall[oh_idx(bus.req_grant)];
    end else if (bus.psel && bus.penable) begin
      if (stall_left != 0)  stall_left <= stall_left - 1;
      else if (bus.pwrite)  mem[bus.paddr] <= bus.pwdata;
      else                  prdata_r <= mem[bus.paddr];
    end
  end
  assign bus.pready = (stall_left == 0);
  assign bus.prdata = prdata_r;

  // Present one request (called just after a rising edge) and hold it until granted
  task automatic drive_one(input int i, input bit wr, input int addr,
                           input logic [31:0] wd, input int stall);
    sb_item_t it;
    int budget;
    it.is_read = !wr;
    it.err     = (TIMEOUT != 0) && (stall >= TIMEOUT);
    it.stall   = stall;
    it.addr    = addr;
    it.rdata   = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
    if (wr && !it.err) ref_mem[addr] = wd;
    exp_q[i].push_back(it);
    v_write[i]   = wr;
    v_addr[i]    = addr[ADDR-1:0];
    v_wdata[i]   = wd;
    cur_stall[i] = stall;
    v_valid[i]   = 1'b1;
    budget = 200;
    do begin
      @(negedge pclk);
      budget--;
    end while (!bus.req_grant[i] && budget > 0);
    checks++;
    if (!bus.req_grant[i]) begin
      failures++;
      $display("FAIL grant_wait req%0d: actual=no grant required=grant within 200 cycles", i);
      void'(exp_q[i].pop_back());
    end
    @(posedge pclk);
    #1;
    v_valid[i] = 1'b0;
  endtask

  task automatic drive_rand(input int i, input int n, input int max_gap, input bit stalls);
    int r;
    int st;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge pclk); #1; end
      r  = int'($urandom_range(0, 19));
      st = !stalls ? 0 : (r < 12) ? 0 : (r < 18) ? int'($urandom_range(1, 3)) : 20;
      drive_one(i, 1'($urandom_range(0, 1)), (i << 8) | int'($urandom_range(0, 7)), $urandom, st);
    end
  endtask

  task automatic wait_idle();
    int budget = 400;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && budget > 0) begin
      @(negedge pclk);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL drain: actual=%0d pending required=0 pending", exp_q[0].size() + exp_q[1].size());
      exp_q[0].delete();
      exp_q[1].delete();
    end
    @(posedge pclk);
    #1;
  endtask

  // Monitor: transaction-level model of arbitration, timing and returned data
  int              cyc;
  bit              pend;
  int              pend_owner;
  int              pend_due;
  bit              free_prev;
  logic [NREQ-1:0] prev_valid;
  int              model_last;
  logic [31:0]     model_rdata;
  logic [ADDR-1:0] s_addr;
  logic            s_write;
  logic [DATA-1:0] s_wdata;

  initial begin
    int       g;
    int       d;
    int       ew;
    int       st;
    sb_item_t it;
    cyc = 0;
    forever begin
      @(negedge pclk);
      cyc++;
      if (preset) begin
        pend        = 1'b0;
        free_prev   = 1'b1;
        prev_valid  = '0;
        model_last  = NREQ - 1;
        model_rdata = '0;
      end else begin
        if (bus.penable) chk("penable_without_psel", 32'(bus.psel), 32'd1);
        if (bus.psel && !bus.penable) begin
          s_addr  = bus.paddr;
          s_write = bus.pwrite;
          s_wdata = bus.pwdata;
        end else if (bus.psel && bus.penable) begin
          chk("paddr_stable", 32'(bus.paddr), 32'(s_addr));
          chk("pwrite_stable", 32'(bus.pwrite), 32'(s_write));
          chk("pwdata_stable", bus.pwdata, s_wdata);
        end

        if (bus.req_grant != '0) begin
          ew = rr_pick(prev_valid, model_last);
          chk("grant_onehot", 32'($onehot(bus.req_grant)), 32'd1);
          chk("grant_when_free", 32'(free_prev && prev_valid != '0), 32'd1);
          chk("grant_owner", 32'(bus.req_grant), (ew >= 0) ? (32'd1 << ew) : 32'd0);
          chk("grant_in_setup", 32'(bus.psel && !bus.penable), 32'd1);
          g  = oh_idx(bus.req_grant);
          model_last = g;
          pend       = 1'b1;
          pend_owner = g;
          st = (exp_q[g].size() != 0) ? exp_q[g][0].stall : 0;
          pend_due = cyc + 3 + ((TIMEOUT == 0 || st < TIMEOUT) ? st : TIMEOUT - 1);
          if (exp_q[g].size() != 0) begin
            chk("grant_paddr", 32'(bus.paddr), 32'(exp_q[g][0].addr[ADDR-1:0]));
            chk("grant_pwrite", 32'(bus.pwrite), 32'(!exp_q[g][0].is_read));
          end
        end else if (free_prev && prev_valid != '0) begin
          checks++;
          failures++;
          $display("FAIL grant_missing: actual=no grant required=grant for valid %b", prev_valid);
        end

        if (bus.req_done != '0) begin
          chk("done_onehot", 32'($onehot(bus.req_done)), 32'd1);
          checks++;
          if (!pend) begin
            failures++;
            $display("FAIL done_unexpected: actual=done %b required=no done", bus.req_done);
          end else begin
            chk("done_owner", 32'(bus.req_done), 32'd1 << pend_owner);
            chk("done_cycle", 32'(cyc), 32'(pend_due));
            pend = 1'b0;
          end
          d = oh_idx(bus.req_done);
          checks++;
          if (exp_q[d].size() == 0) begin
            failures++;
            $display("FAIL done_no_request: actual=done for req%0d required=no done", d);
          end else begin
            it = exp_q[d].pop_front();
            chk("req_err", 32'(bus.req_err), 32'(it.err));
            if (it.is_read && !it.err) model_rdata = it.rdata;
            chk("req_rdata", bus.req_rdata, model_rdata);
            $display("txn req%0d %s addr=%03h err=%0d rdata=%08h stall=%0d",
                     d, it.is_read ? "rd" : "wr", it.addr, bus.req_err, bus.req_rdata, it.stall);
          end
        end else begin
          chk("err_without_done", 32'(bus.req_err), 32'd0);
          if (pend && cyc > pend_due) begin
            checks++;
            failures++;
            $display("FAIL done_missing: actual=no done by cycle %0d required=done at %0d", cyc, pend_due);
            pend = 1'b0;
          end
        end
        free_prev  = !pend;
        prev_valid = bus.req_valid;
      end
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_psel"}, 32'(bus.psel), 32'd0);
    chk({tag, "_penable"}, 32'(bus.penable), 32'd0);
    chk({tag, "_pwrite"}, 32'(bus.pwrite), 32'd0);
    chk({tag, "_paddr"}, 32'(bus.paddr), 32'd0);
    chk({tag, "_pwdata"}, bus.pwdata, 32'd0);
    chk({tag, "_grant"}, 32'(bus.req_grant), 32'd0);
    chk({tag, "_done"}, 32'(bus.req_done), 32'd0);
    chk({tag, "_err"}, 32'(bus.req_err), 32'd0);
    chk({tag, "_rdata"}, bus.req_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=simulation still running required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int k = 0; k < NREQ; k++) begin
      v_addr[k]  = '0;
      v_wdata[k] = '0;
    end
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    chk_outputs_zero("reset");
    preset = 1'b0;
    @(posedge pclk);
    #1;

    // Simultaneous requests right after reset: requester 0 wins first
    fork
      drive_one(0, 1'b1, 10'h010, 32'h1111_0000, 0);
      drive_one(1, 1'b1, 10'h110, 32'h2222_0000, 0);
    join
    wait_idle();

    // Single requester write then read back
    drive_one(0, 1'b1, 10'h005, 32'hDEAD_BEEF, 0);
    drive_one(0, 1'b0, 10'h005, 32'h0, 0);
    wait_idle();

    // Three wait states, then timeouts on a read and on a write
    drive_one(0, 1'b0, 10'h005, 32'h0, 3);
    drive_one(1, 1'b0, 10'h110, 32'h0, 20);
    drive_one(0, 1'b1, 10'h006, 32'hCAFE_F00D, 20);
    drive_one(0, 1'b0, 10'h006, 32'h0, 0);
    wait_idle();

    // Both requesters continuously valid: strict alternation
    fork
      drive_rand(0, 4, 0, 1'b0);
      drive_rand(1, 4, 0, 1'b0);
    join
    wait_idle();

    // Random traffic with gaps, wait states and occasional aborts
    fork
      drive_rand(0, 15, 2, 1'b1);
      drive_rand(1, 15, 2, 1'b1);
    join
    wait_idle();

    // Reset in the middle of an ACCESS phase: outputs drop at once, no completion
    drive_one(0, 1'b0, 10'h003, 32'h0, 10);
    @(posedge pclk);
    #1;
    preset = 1'b1;
    ref_mem.delete();
    exp_q[0].delete();
    exp_q[1].delete();
    #1;
    chk_outputs_zero("midreset");
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    repeat (8) begin @(posedge pclk); #1; end
    drive_one(1, 1'b1, 10'h104, 32'h5A5A_A5A5, 0);
    drive_one(1, 1'b0, 10'h104, 32'h0, 0);
    wait_idle();

    repeat (4) @(posedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
